shared_memory_arbiter: RTL and testbench

//  Parametrised N-port backing-memory controller. Serves the memory_request/memory_response handshakes of NUM_PORTS caches from one shared byte-addressed store.

---
 rtl/shared_memory_arbiter.sv | 157 +++++++++++++++
 tb/tb_shared_memory_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_memory_arbiter.sv
// N-port round-robin arbiter in front of one shared byte store; one transaction in
// flight, programmable latency, whole-line responses with write-through bypass.
module shared_memory_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 8,
  parameter int LINE_BYTES     = 2,
  parameter int MEM_LATENCY    = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_PORTS*(1+DATA_W+ADDR_W)-1:0] memory_request,
  input  logic [NUM_PORTS-1:0]                   memory_request_ready,
  output logic [NUM_PORTS*LINE_BYTES*DATA_W-1:0] memory_response,
  output logic [NUM_PORTS-1:0]                   memory_response_ready
);
  localparam int REQ_W  = 1 + DATA_W + ADDR_W;
  localparam int LINE_W = LINE_BYTES * DATA_W;
  localparam int PW     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LO     = ADDR_W / 2;
  localparam int ROWS   = 1 << (ADDR_W - LO);
  localparam int COLS   = 1 << LO;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                          state_q, state_d;
  logic [PW-1:0]                   ptr_q, ptr_d, gnt_q, gnt_d, gnt_next, pick;
  logic [7:0]                      cnt_q, cnt_d;
  logic                            wr_q, wr_d;
  logic [DATA_W-1:0]               data_q, data_d;
  logic [ADDR_W-1:0]               addr_q, addr_d, base;
  logic [NUM_PORTS-1:0][LINE_W-1:0] resp_q, resp_d;
  logic [NUM_PORTS-1:0]            rdy_q, rdy_d;
  logic                            req_any, mem_we;
  logic [LINE_W-1:0]               line_rd;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [COLS-1:0]   vld_rows [ROWS];

  // Clearing the store on reset is done with per-byte valid bits; a byte whose
  // bit is low reads as zero regardless of what the data array still holds.
  for (genvar r = 0; r < ROWS; r++) begin : g_vld
    logic [COLS-1:0] row_q;
    always_ff @(posedge clock) begin
      if (reset) begin
        if (CLEAR_ON_RESET != 0) row_q <= '0;
      end else if (mem_we && addr_q[ADDR_W-1:LO] == (ADDR_W-LO)'(r)) begin
        row_q[addr_q[LO-1:0]] <= 1'b1;
      end
    end
    assign vld_rows[r] = row_q;
  end

  always_ff @(posedge clock) begin
    if (!reset && mem_we) mem_q[addr_q] <= data_q;
  end

  function automatic logic [DATA_W-1:0] rd_byte(input logic [ADDR_W-1:0] a);
    if (CLEAR_ON_RESET == 0 || vld_rows[a[ADDR_W-1:LO]][a[LO-1:0]]) return mem_q[a];
    return '0;
  endfunction

  assign base = addr_q & ~ADDR_W'(LINE_BYTES - 1);

  // The pending write byte is bypassed into the line so it reads back this cycle.
  always_comb begin
    line_rd = '0;
    for (int i = 0; i < LINE_BYTES; i++) begin
      if (wr_q && (base + ADDR_W'(i)) == addr_q) line_rd[i*DATA_W +: DATA_W] = data_q;
      else                                       line_rd[i*DATA_W +: DATA_W] = rd_byte(base + ADDR_W'(i));
    end
  end

  // Scan downwards so the requester closest to the pointer wins.
  always_comb begin
    pick    = ptr_q;
    req_any = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (memory_request_ready[(int'(ptr_q) + i) % NUM_PORTS]) begin
        pick    = PW'((int'(ptr_q) + i) % NUM_PORTS);
        req_any = 1'b1;
      end
    end
  end

  assign gnt_next = (int'(gnt_q) == NUM_PORTS - 1) ? '0 : gnt_q + 1'b1;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    data_d  = data_q;
    addr_d  = addr_q;
    resp_d  = resp_q;
    rdy_d   = rdy_q;
    mem_we  = 1'b0;
    case (state_q)
      IDLE: if (req_any) begin
        gnt_d                    = pick;
        {wr_d, data_d, addr_d}   = memory_request[int'(pick)*REQ_W +: REQ_W];
        cnt_d                    = 8'(MEM_LATENCY);
        state_d                  = BUSY;
      end
      BUSY: if (cnt_q != 8'd0) begin
        cnt_d = cnt_q - 8'd1;
      end else begin
        mem_we = wr_q;
        if (memory_request_ready[gnt_q]) begin
          resp_d[gnt_q] = line_rd;
          rdy_d[gnt_q]  = 1'b1;
          state_d       = RESP;
        end else begin
          ptr_d   = gnt_next;
          state_d = IDLE;
        end
      end
      RESP: if (!memory_request_ready[gnt_q]) begin
        resp_d[gnt_q] = '0;
        rdy_d[gnt_q]  = 1'b0;
        ptr_d         = gnt_next;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      resp_q  <= '0;
      rdy_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      resp_q  <= resp_d;
      rdy_q   <= rdy_d;
    end
  end

  assign memory_response       = resp_q;
  assign memory_response_ready = rdy_q;
endmodule

// File: tb/tb_shared_memory_arbiter.sv
// Scoreboard bench for shared_memory_arbiter: three instances (default, 3-cycle
// latency, 4-port/4-byte line) driven by directed transactions.
module tb_shared_memory_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  int compared = 0, mismatched = 0;

  typedef struct {int port; logic [31:0] line; int cyc;} exp_t;
  exp_t q_def[$], q_lat[$], q_q4[$];
  int n_def = 0, n_lat = 0, n_q4 = 0;
  int x_def = 0, x_lat = 0, x_q4 = 0;

  logic         rst_def = 1'b1, rst_lat = 1'b1, rst_q4 = 1'b1;
  logic [49:0]  req_def = '0, req_lat = '0;
  logic [1:0]   rr_def = '0, rr_lat = '0;
  logic [31:0]  resp_def, resp_lat;
  logic [1:0]   rdy_def, rdy_lat;
  logic [99:0]  req_q4 = '0;
  logic [3:0]   rr_q4 = '0;
  logic [127:0] resp_q4;
  logic [3:0]   rdy_q4;

  shared_memory_arbiter u_def (
    .clock(clock), .reset(rst_def), .memory_request(req_def), .memory_request_ready(rr_def),
    .memory_response(resp_def), .memory_response_ready(rdy_def));

  shared_memory_arbiter #(.MEM_LATENCY(3)) u_lat (
    .clock(clock), .reset(rst_lat), .memory_request(req_lat), .memory_request_ready(rr_lat),
    .memory_response(resp_lat), .memory_response_ready(rdy_lat));

  shared_memory_arbiter #(.NUM_PORTS(4), .LINE_BYTES(4)) u_q4 (
    .clock(clock), .reset(rst_q4), .memory_request(req_q4), .memory_request_ready(rr_q4),
    .memory_response(resp_q4), .memory_response_ready(rdy_q4));

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  function automatic logic [24:0] mk(input logic wr, input logic [7:0] d, input logic [15:0] a);
    return {wr, d, a};
  endfunction

  task automatic push(input int d, input int p, input logic [31:0] line, input int c);
    exp_t e;
    e.port = p; e.line = line; e.cyc = c;
    case (d)
      0: begin q_def.push_back(e); x_def++; end
      1: begin q_lat.push_back(e); x_lat++; end
      default: begin q_q4.push_back(e); x_q4++; end
    endcase
  endtask

  task automatic score(input int d, input int p, input logic [31:0] line, input int ones);
    exp_t e;
    bit have;
    chk($sformatf("onehot_d%0d", d), 32'(ones), 32'd1);
    case (d)
      0: begin have = q_def.size() > 0; if (have) e = q_def.pop_front(); end
      1: begin have = q_lat.size() > 0; if (have) e = q_lat.pop_front(); end
      default: begin have = q_q4.size() > 0; if (have) e = q_q4.pop_front(); end
    endcase
    if (!have) begin
      chk($sformatf("unexpected_resp_d%0d", d), 32'(p), 32'hFFFF_FFFF);
    end else begin
      chk($sformatf("port_d%0d", d), 32'(p), 32'(e.port));
      chk($sformatf("line_d%0d_p%0d", d, p), line, e.line);
      if (e.cyc >= 0) chk($sformatf("latency_d%0d_p%0d", d, p), 32'(cyc), 32'(e.cyc));
    end
  endtask

  logic [1:0] pv_def = '0, pv_lat = '0;
  logic [3:0] pv_q4 = '0;
  always @(negedge clock) begin
    for (int p = 0; p < 2; p++)
      if (rdy_def[p] && !pv_def[p]) begin
        n_def++;
        score(0, p, {16'h0, resp_def[p*16 +: 16]}, $countones(rdy_def));
      end
    for (int p = 0; p < 2; p++)
      if (rdy_lat[p] && !pv_lat[p]) begin
        n_lat++;
        score(1, p, {16'h0, resp_lat[p*16 +: 16]}, $countones(rdy_lat));
      end
    for (int p = 0; p < 4; p++)
      if (rdy_q4[p] && !pv_q4[p]) begin
        n_q4++;
        score(2, p, resp_q4[p*32 +: 32], $countones(rdy_q4));
      end
    pv_def = rdy_def;
    pv_lat = rdy_lat;
    pv_q4  = rdy_q4;
  end

  task automatic wait_rdy(input int d, input int p, input bit drop);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < 100) begin
      @(negedge clock);
      n++;
      hit = (d == 0) ? rdy_def[p] : (d == 1) ? rdy_lat[p] : rdy_q4[p];
    end
    chk($sformatf("wait_rdy_d%0d_p%0d", d, p), 32'(hit), 32'd1);
    if (drop)
      case (d)
        0: rr_def[p] = 1'b0;
        1: rr_lat[p] = 1'b0;
        default: rr_q4[p] = 1'b0;
      endcase
  endtask

  task automatic def_req(input int p, input logic wr, input logic [7:0] dt, input logic [15:0] a);
    req_def[p*25 +: 25] = mk(wr, dt, a);
    rr_def[p] = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    rst_def = 1'b0; rst_lat = 1'b0; rst_q4 = 1'b0;
    @(negedge clock);
    chk("rst_resp_def", resp_def, 32'h0);
    chk("rst_rdy_def", 32'(rdy_def), 32'h0);
    chk("rst_rdy_lat", 32'(rdy_lat), 32'h0);
    chk("rst_resp_q4_or", 32'(|resp_q4), 32'h0);

    // Write through port0, then read the same line from port1.
    def_req(0, 1'b1, 8'h10, 16'h0017); push(0, 0, 32'h1000, cyc + 2);
    wait_rdy(0, 0, 1'b1);
    @(negedge clock);
    chk("t1_resp_clr", resp_def, 32'h0);
    chk("t1_rdy_clr", 32'(rdy_def), 32'h0);
    def_req(1, 1'b0, 8'h00, 16'h0017); push(0, 1, 32'h1000, cyc + 2);
    wait_rdy(0, 1, 1'b1);
    @(negedge clock);

    // Simultaneous pair with pointer at 0: port0 first.
    def_req(0, 1'b0, 8'h00, 16'h0016); def_req(1, 1'b0, 8'h00, 16'h0030);
    push(0, 0, 32'h1000, cyc + 2); push(0, 1, 32'h0000, cyc + 5);
    wait_rdy(0, 0, 1'b1); wait_rdy(0, 1, 1'b1);
    @(negedge clock);
    // Lone port0 leaves pointer at 1, so the next pair starts with port1.
    def_req(0, 1'b0, 8'h00, 16'h0017); push(0, 0, 32'h1000, cyc + 2);
    wait_rdy(0, 0, 1'b1);
    @(negedge clock);
    def_req(0, 1'b0, 8'h00, 16'h0030); def_req(1, 1'b0, 8'h00, 16'h0016);
    push(0, 1, 32'h1000, cyc + 2); push(0, 0, 32'h0000, cyc + 5);
    wait_rdy(0, 1, 1'b1); wait_rdy(0, 0, 1'b1);
    @(negedge clock);

    // Write withdrawn while BUSY: committed, but no response.
    def_req(0, 1'b1, 8'hFF, 16'h0040);
    @(negedge clock); rr_def[0] = 1'b0;
    repeat (2) @(negedge clock);
    chk("t4_no_rdy", 32'(rdy_def), 32'h0);
    def_req(1, 1'b0, 8'h00, 16'h0040); push(0, 1, 32'h00FF, cyc + 2);
    wait_rdy(0, 1, 1'b1);
    @(negedge clock);

    // Reset while the write is in BUSY aborts it and clears the store.
    def_req(0, 1'b1, 8'hAA, 16'h0005);
    @(negedge clock); rst_def = 1'b1;
    @(negedge clock); rst_def = 1'b0; rr_def[0] = 1'b0;
    chk("t5_resp_rst", resp_def, 32'h0);
    chk("t5_rdy_rst", 32'(rdy_def), 32'h0);
    @(negedge clock);
    def_req(0, 1'b0, 8'h00, 16'h0004); push(0, 0, 32'h0000, cyc + 2);
    wait_rdy(0, 0, 1'b1);
    @(negedge clock);
    def_req(1, 1'b0, 8'h00, 16'h0016); push(0, 1, 32'h0000, cyc + 2);
    wait_rdy(0, 1, 1'b1);
    @(negedge clock);

    // Latency 3: response four cycles after grant, held until request drops.
    req_lat[25 +: 25] = mk(1'b1, 8'h5A, 16'h0023); rr_lat[1] = 1'b1;
    push(1, 1, 32'h5A00, cyc + 5);
    wait_rdy(1, 1, 1'b1);
    @(negedge clock);
    req_lat[0 +: 25] = mk(1'b0, 8'h00, 16'h0022); rr_lat[0] = 1'b1;
    push(1, 0, 32'h5A00, cyc + 5);
    wait_rdy(1, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("t3_hold_data", {16'h0, resp_lat[15:0]}, 32'h5A00);
      chk("t3_hold_rdy", 32'(rdy_lat), 32'h1);
    end
    rr_lat[0] = 1'b0;
    @(negedge clock);
    chk("t3_resp_clr", resp_lat, 32'h0);
    chk("t3_rdy_clr", 32'(rdy_lat), 32'h0);

    // Four ports at once; port0 comes back and must wait behind 1,2,3.
    req_q4[0  +: 25] = mk(1'b1, 8'hA0, 16'h0100);
    req_q4[25 +: 25] = mk(1'b1, 8'hA1, 16'h0101);
    req_q4[50 +: 25] = mk(1'b1, 8'hA2, 16'h0102);
    req_q4[75 +: 25] = mk(1'b1, 8'hA3, 16'h0103);
    rr_q4 = 4'hF;
    push(2, 0, 32'h0000_00A0, cyc + 2);
    push(2, 1, 32'h0000_A1A0, cyc + 5);
    push(2, 2, 32'h00A2_A1A0, cyc + 8);
    push(2, 3, 32'hA3A2_A1A0, cyc + 11);
    push(2, 0, 32'hA3A2_A1A0, cyc + 14);
    wait_rdy(2, 0, 1'b1);
    @(negedge clock);
    req_q4[0 +: 25] = mk(1'b0, 8'h00, 16'h0103); rr_q4[0] = 1'b1;
    wait_rdy(2, 1, 1'b1);
    wait_rdy(2, 2, 1'b1);
    wait_rdy(2, 3, 1'b1);
    wait_rdy(2, 0, 1'b1);
    repeat (2) @(negedge clock);
    chk("q4_idle_rdy", 32'(rdy_q4), 32'h0);

    chk("def_nresp", 32'(n_def), 32'(x_def));
    chk("lat_nresp", 32'(n_lat), 32'(x_lat));
    chk("q4_nresp", 32'(n_q4), 32'(x_q4));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
